// File: rtl/alu_op_decoder.sv
// RV32I decode/issue stage: turns an instruction plus operands into ALU control, both ALU operands
// and side-band controls, held in a single valid/ready ID/EX register.
module alu_op_decoder #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic [XLEN-1:0]   pc,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        alu_control,
  output logic [XLEN-1:0]   left_operand,
  output logic [XLEN-1:0]   right_operand,
  output logic [REG_AW-1:0] rd,
  output logic              reg_write,
  output logic              mem_read,
  output logic              mem_write,
  output logic              is_branch,
  output logic              is_jump,
  output logic [XLEN-1:0]   target,
  output logic              illegal
);

  localparam logic [3:0] AluAdd  = 4'd0;
  localparam logic [3:0] AluSub  = 4'd1;
  localparam logic [3:0] AluSll  = 4'd2;
  localparam logic [3:0] AluSlt  = 4'd3;
  localparam logic [3:0] AluSltu = 4'd4;
  localparam logic [3:0] AluXor  = 4'd5;
  localparam logic [3:0] AluSrl  = 4'd6;
  localparam logic [3:0] AluSra  = 4'd7;
  localparam logic [3:0] AluOr   = 4'd8;
  localparam logic [3:0] AluAnd  = 4'd9;
  localparam logic [3:0] BBeq    = 4'd10;
  localparam logic [3:0] BBne    = 4'd11;
  localparam logic [3:0] BBlt    = 4'd12;
  localparam logic [3:0] BBge    = 4'd13;
  localparam logic [3:0] BLtu    = 4'd14;
  localparam logic [3:0] BGeu    = 4'd15;

  typedef struct packed {
    logic [3:0]        alu;
    logic [XLEN-1:0]   lop;
    logic [XLEN-1:0]   rop;
    logic [REG_AW-1:0] rd;
    logic              rw;
    logic              mr;
    logic              mw;
    logic              br;
    logic              jp;
    logic [XLEN-1:0]   tgt;
    logic              ill;
  } op_t;

  op_t  op_q, op_d, dec;
  logic valid_q, valid_d;
  logic load;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  function automatic logic [3:0] alu_map(input logic [2:0] f3, input logic alt);
    logic [3:0] code;
    unique case (f3)
      3'd0:    code = alt ? AluSub : AluAdd;
      3'd1:    code = AluSll;
      3'd2:    code = AluSlt;
      3'd3:    code = AluSltu;
      3'd4:    code = AluXor;
      3'd5:    code = alt ? AluSra : AluSrl;
      3'd6:    code = AluOr;
      default: code = AluAnd;
    endcase
    return code;
  endfunction

  always_comb begin
    dec     = '0;
    dec.alu = AluAdd;
    dec.rd  = instr[11:7];
    unique case (opcode)
      7'b0110011: begin
        if (funct7 == 7'h00 || (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5))) begin
          dec.alu = alu_map(funct3, funct7[5]);
          dec.lop = rs1_data;
          dec.rop = rs2_data;
          dec.rw  = 1'b1;
        end else begin
          dec.ill = 1'b1;
        end
      end
      7'b0010011: begin
        // Only shifts take the alternate encoding; ADDI never becomes SUB.
        dec.alu = alu_map(funct3, funct3 == 3'd5 && instr[30]);
        dec.lop = rs1_data;
        dec.rop = (funct3 == 3'd1 || funct3 == 3'd5) ? {27'b0, instr[24:20]} : imm_i;
        dec.rw  = 1'b1;
      end
      7'b0110111: begin
        dec.rop = imm_u;
        dec.rw  = 1'b1;
      end
      7'b0010111: begin
        dec.lop = pc;
        dec.rop = imm_u;
        dec.rw  = 1'b1;
      end
      7'b0000011: begin
        dec.lop = rs1_data;
        dec.rop = imm_i;
        dec.rw  = 1'b1;
        dec.mr  = 1'b1;
      end
      7'b0100011: begin
        dec.lop = rs1_data;
        dec.rop = imm_s;
        dec.mw  = 1'b1;
      end
      7'b1100011: begin
        dec.lop = rs1_data;
        dec.rop = rs2_data;
        dec.br  = 1'b1;
        dec.tgt = pc + imm_b;
        unique case (funct3)
          3'd0:    dec.alu = BBeq;
          3'd1:    dec.alu = BBne;
          3'd4:    dec.alu = BBlt;
          3'd5:    dec.alu = BBge;
          3'd6:    dec.alu = BLtu;
          3'd7:    dec.alu = BGeu;
          default: dec.ill = 1'b1;
        endcase
      end
      7'b1101111: begin
        dec.lop = pc;
        dec.rop = 32'd4;
        dec.rw  = 1'b1;
        dec.jp  = 1'b1;
        dec.tgt = pc + imm_j;
      end
      7'b1100111: begin
        dec.lop = pc;
        dec.rop = 32'd4;
        dec.rw  = 1'b1;
        dec.jp  = 1'b1;
        dec.tgt = (rs1_data + imm_i) & ~32'd1;
        dec.ill = (funct3 != 3'd0);
      end
      default: dec.ill = 1'b1;
    endcase
    // Illegal ops collapse to an inert ADD 0,0 with no side effects.
    if (dec.ill) begin
      dec     = '0;
      dec.alu = AluAdd;
      dec.ill = 1'b1;
    end
    if (dec.rd == '0) dec.rw = 1'b0;
  end

  assign in_ready = !valid_q || out_ready;
  assign load     = in_valid && in_ready;

  always_comb begin
    op_d = load ? dec : op_q;
    if (flush)          valid_d = 1'b0;
    else if (load)      valid_d = 1'b1;
    else if (out_ready) valid_d = 1'b0;
    else                valid_d = valid_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      op_q    <= '0;
    end else begin
      valid_q <= valid_d;
      op_q    <= op_d;
    end
  end

  assign out_valid     = valid_q;
  assign alu_control   = op_q.alu;
  assign left_operand  = op_q.lop;
  assign right_operand = op_q.rop;
  assign rd            = op_q.rd;
  assign reg_write     = op_q.rw;
  assign mem_read      = op_q.mr;
  assign mem_write     = op_q.mw;
  assign is_branch     = op_q.br;
  assign is_jump       = op_q.jp;
  assign target        = op_q.tgt;
  assign illegal       = op_q.ill;

endmodule

// File: tb/tb_alu_op_decoder.sv
// Bench for alu_op_decoder: a reference decoder/pipeline model checked every cycle, plus
// hand-computed expectations for the directed vectors.
module tb_alu_op_decoder;

  localparam logic [3:0] ADD = 0, SUB = 1, SLL = 2, SLT = 3, SLTU = 4, XOR = 5, SRL = 6, SRA = 7;
  localparam logic [3:0] OR = 8, AND = 9, BEQ = 10, BNE = 11, BLT = 12, BGE = 13, BLTU = 14;
  localparam logic [3:0] BGEU = 15;

  logic        clk = 0, reset = 1;
  logic        in_valid = 0, flush = 0, out_ready = 1;
  logic [31:0] instr = 0, pc = 0, rs1_data = 0, rs2_data = 0;
  logic        in_ready, out_valid, reg_write, mem_read, mem_write, is_branch, is_jump, illegal;
  logic [3:0]  alu_control;
  logic [31:0] left_operand, right_operand, target;
  logic [4:0]  rd;

  int tests = 0, fails = 0;

  alu_op_decoder dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .instr(instr), .pc(pc),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .alu_control(alu_control), .left_operand(left_operand),
    .right_operand(right_operand), .rd(rd), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .is_branch(is_branch), .is_jump(is_jump), .target(target),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  // {alu, L, R, rd, rw, mr, mw, br, jp, target, illegal}
  typedef logic [110:0] vec_t;

  function automatic vec_t ref_op(input logic [31:0] ins, input logic [31:0] p,
                                  input logic [31:0] a, input logic [31:0] b);
    logic [3:0]  base [8] = '{ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND};
    logic [3:0]  bcode [8] = '{BEQ, BNE, ADD, ADD, BLT, BGE, BLTU, BGEU};
    logic [2:0]  f3 = ins[14:12];
    logic [6:0]  f7 = ins[31:25];
    logic [4:0]  d = ins[11:7];
    logic signed [11:0] si = ins[31:20];
    logic signed [11:0] ss = {ins[31:25], ins[11:7]};
    logic signed [12:0] sb = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    logic signed [20:0] sj = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    logic [31:0] ii = 32'(si), is_ = 32'(ss), ib = 32'(sb), ij = 32'(sj);
    logic [31:0] iu = {ins[31:12], 12'h000};
    logic [3:0]  alu = ADD;
    logic [31:0] l = 0, r = 0, t = 0;
    logic        rw = 0, mr = 0, mw = 0, br = 0, jp = 0, bad = 0;
    case (ins[6:0])
      7'h33: begin
        bad = !(f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)));
        alu = (f7 == 7'h20) ? ((f3 == 0) ? SUB : SRA) : base[f3];
        l = a; r = b; rw = 1;
      end
      7'h13: begin
        alu = (f3 == 5 && ins[30]) ? SRA : base[f3];
        l = a; r = (f3 == 1 || f3 == 5) ? 32'(ins[24:20]) : ii; rw = 1;
      end
      7'h37: begin r = iu; rw = 1; end
      7'h17: begin l = p; r = iu; rw = 1; end
      7'h03: begin l = a; r = ii; rw = 1; mr = 1; end
      7'h23: begin l = a; r = is_; mw = 1; end
      7'h63: begin alu = bcode[f3]; bad = (f3 == 2 || f3 == 3); l = a; r = b; br = 1; t = p + ib; end
      7'h6F: begin l = p; r = 4; rw = 1; jp = 1; t = p + ij; end
      7'h67: begin l = p; r = 4; rw = 1; jp = 1; t = (a + ii) & 32'hFFFF_FFFE; bad = (f3 != 0); end
      default: bad = 1;
    endcase
    if (bad) return {ADD, 32'h0, 32'h0, 5'h0, 5'b0, 32'h0, 1'b1};
    if (d == 0) rw = 0;
    return {alu, l, r, d, rw, mr, mw, br, jp, t, 1'b0};
  endfunction

  vec_t dut_vec;
  assign dut_vec = {alu_control, left_operand, right_operand, rd, reg_write, mem_read, mem_write,
                    is_branch, is_jump, target, illegal};

  task automatic chk(input string name, input vec_t act, input vec_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference pipeline register.
  logic m_valid = 0;
  vec_t m_op = '0;
  always @(posedge clk or posedge reset) begin
    if (reset) m_valid <= 0;
    else if (flush) m_valid <= 0;
    else if (in_valid && (!m_valid || out_ready)) begin
      m_valid <= 1;
      m_op    <= ref_op(instr, pc, rs1_data, rs2_data);
    end else if (out_ready) m_valid <= 0;
  end

  always @(negedge clk) begin
    chk("out_valid", vec_t'(out_valid), vec_t'(m_valid));
    chk("in_ready", vec_t'(in_ready), vec_t'(!m_valid || out_ready));
    if (m_valid) chk("outputs", dut_vec, m_op);
  end

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] p,
                       input logic [31:0] a, input logic [31:0] b, input logic ordy,
                       input logic fl);
    @(negedge clk); #1;
    in_valid = v; instr = ins; pc = p; rs1_data = a; rs2_data = b; out_ready = ordy; flush = fl;
    @(posedge clk); #1;
  endtask

  vec_t snap;

  initial begin
    #1;
    chk("reset out_valid", vec_t'(out_valid), 0);
    chk("reset outputs", dut_vec, '0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1 reset = 0;

    drive(1, 32'h002081B3, 32'h0, 5, 7, 1, 0);
    chk("add", {out_valid, dut_vec}, {1'b1, ADD, 32'd5, 32'd7, 5'd3, 5'b10000, 32'h0, 1'b0});
    drive(1, 32'h4040D093, 32'h4, 32'h8000_0000, 0, 1, 0);
    chk("srai alu", vec_t'(alu_control), vec_t'(SRA));
    chk("srai r", vec_t'(right_operand), 4);
    drive(1, 32'hFFF00013, 32'h8, 9, 0, 1, 0);
    chk("addi x0", {alu_control, right_operand, reg_write}, {ADD, 32'hFFFF_FFFF, 1'b0});
    drive(1, 32'hFE209CE3, 32'h100, 11, 22, 1, 0);
    chk("bne", {alu_control, left_operand, right_operand, is_branch, reg_write, target},
        {BNE, 32'd11, 32'd22, 1'b1, 1'b0, 32'h0000_00F8});
    drive(1, 32'h000100E7, 32'h200, 32'h203, 0, 1, 0);
    chk("jalr", {is_jump, left_operand, right_operand, target}, {1'b1, 32'h200, 32'd4, 32'h202});
    drive(1, 32'h0000007F, 32'h0, 1, 2, 1, 0);
    chk("illegal", {illegal, reg_write, mem_write, mem_read, is_branch, is_jump}, 6'b100000);
    // Misc coverage via the model: SUB, bad funct7, LUI, AUIPC, LW, SW, JAL, BEQ funct3=2, SLTIU.
    drive(1, 32'h40208133, 0, 30, 8, 1, 0);
    chk("sub", vec_t'(alu_control), vec_t'(SUB));
    drive(1, 32'h02208133, 0, 1, 1, 1, 0);
    drive(1, 32'h123452B7, 0, 1, 1, 1, 0);
    drive(1, 32'hFFFFF317, 32'h1000, 0, 0, 1, 0);
    drive(1, 32'hFFC12383, 0, 32'h40, 0, 1, 0);
    drive(1, 32'hFE312E23, 0, 32'h40, 5, 1, 0);
    drive(1, 32'hFF9FF0EF, 32'h4, 0, 0, 1, 0);
    chk("jal wrap", vec_t'(target), 32'hFFFF_FFFC);
    drive(1, 32'h00112063, 0, 1, 1, 1, 0);
    drive(1, 32'hFFF0B193, 0, 3, 0, 1, 0);

    // Backpressure: three stalled cycles, then drain one op per cycle.
    drive(1, 32'h002081B3, 0, 100, 200, 0, 0);
    snap = dut_vec;
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h00310233 + 32'(i << 7), 0, i, i, 0, 0);
      chk("stall in_ready", vec_t'(in_ready), 0);
      chk("stall stable", dut_vec, snap);
    end
    for (int i = 0; i < 4; i++) drive(1, 32'h00310233 + 32'(i << 7), 0, 10 + i, 1, 1, 0);
    drive(0, 0, 0, 0, 0, 1, 0);
    chk("drained", vec_t'(out_valid), 0);

    // Flush beats a simultaneous input while an op is held.
    drive(1, 32'h002081B3, 0, 1, 2, 0, 0);
    drive(1, 32'h002081B3, 0, 3, 4, 0, 1);
    chk("flush", vec_t'(out_valid), 0);
    drive(1, 32'h002081B3, 0, 5, 6, 1, 0);
    chk("post flush", vec_t'({out_valid, left_operand}), {1'b1, 32'd5});

    // Asynchronous reset while holding an op.
    drive(1, 32'h002081B3, 0, 7, 8, 0, 0);
    @(negedge clk); #1 reset = 1; in_valid = 0;
    #1 chk("async reset", vec_t'(out_valid), 0);
    @(negedge clk); #1 reset = 0;
    drive(1, 32'h00208133, 0, 9, 9, 1, 0);
    chk("after reset", vec_t'({out_valid, rd}), {1'b1, 5'd2});
    drive(0, 0, 0, 0, 0, 1, 0);
    @(negedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
